// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register-bank readout controller.
package reg_dump_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    SHOW_HI  = 3'd2,
    SHOW_IDX = 3'd3,
    SUM_LO   = 3'd4,
    SUM_HI   = 3'd5
  } state_t;

  // LED word shown when a new sequence is armed
  localparam logic [15:0] START_CODE = 16'h0001;

  // Highest register index; a scan stops here instead of wrapping
  localparam logic [4:0] LAST_REG = 5'd31;

  // Zero-extended register index as an LED word
  function automatic logic [15:0] idx_to_led(input logic [4:0] idx);
    return {11'b0, idx};
  endfunction

endpackage

// File: rtl/reg_dump_ctrl_nxt_pulse.sv
// Step-button conditioner: two-flop synchronizer plus rising-edge detector.
// Flops reset high so a button already held through reset gives no pulse.
module nxt_pulse (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic pe
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Synchronize the button and keep one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= sig;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign pe = r_s2 & ~r_s3;

endmodule

// File: rtl/reg_dump_ctrl.sv
// Register-bank readout controller: steps through low half, high half and
// index of a selected register on the LEDs, or scans to the last register
// and then shows the XOR checksum of every register visited.
module reg_dump_ctrl
  import reg_dump_pkg::*;
#(
  parameter int unsigned NREG_LOG2 = 5,
  parameter int unsigned DW        = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          in,
  input  logic                 nxt,
  output logic [NREG_LOG2-1:0] rd_addr,
  input  logic [DW-1:0]        rd_data,
  output logic                 busy,
  output logic [15:0]          out
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NREG_LOG2-1:0] r_addr;
  logic [NREG_LOG2-1:0] w_addr_nxt;
  logic                 r_scan;
  logic                 w_scan_nxt;
  logic [DW-1:0]        r_data_q;
  logic [DW-1:0]        w_data_nxt;
  logic [DW-1:0]        r_sum;
  logic [DW-1:0]        w_sum_nxt;
  logic [15:0]          r_out;
  logic [15:0]          w_out_nxt;
  logic                 w_pe;
  logic                 w_last;
  logic                 w_unused;

  nxt_pulse u_nxt_pulse (
    .clk   (clk),
    .reset (reset),
    .sig   (nxt),
    .pe    (w_pe)
  );

  assign w_last   = (r_addr == NREG_LOG2'(LAST_REG));
  assign rd_addr  = r_addr;
  assign busy     = (r_state != IDLE);
  assign out      = r_out;
  // Switch bits 14..start-width and the captured low half are not displayed from
  assign w_unused = ^{in[14:NREG_LOG2], r_data_q[15:0]};

  // State and datapath registers; everything holds unless a step pulse arrives
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_scan   <= 1'b0;
      r_data_q <= '0;
      r_sum    <= '0;
      r_out    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_addr   <= w_addr_nxt;
      r_scan   <= w_scan_nxt;
      r_data_q <= w_data_nxt;
      r_sum    <= w_sum_nxt;
      r_out    <= w_out_nxt;
    end
  end

  // Next-state and datapath updates, evaluated only on a step pulse
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_scan_nxt  = r_scan;
    w_data_nxt  = r_data_q;
    w_sum_nxt   = r_sum;
    w_out_nxt   = r_out;
    if (w_pe) begin
      case (r_state)
        IDLE: begin
          w_addr_nxt  = in[NREG_LOG2-1:0];
          w_scan_nxt  = in[15];
          w_sum_nxt   = '0;
          w_out_nxt   = START_CODE;
          w_state_nxt = FETCH;
        end
        FETCH: begin
          w_data_nxt  = rd_data;
          w_sum_nxt   = r_sum ^ rd_data;
          w_out_nxt   = rd_data[15:0];
          w_state_nxt = SHOW_HI;
        end
        SHOW_HI: begin
          w_out_nxt   = r_data_q[31:16];
          w_state_nxt = SHOW_IDX;
        end
        SHOW_IDX: begin
          w_out_nxt = idx_to_led(5'(r_addr));
          if (r_scan && !w_last) begin
            w_addr_nxt  = r_addr + 1'b1;
            w_state_nxt = FETCH;
          end else if (r_scan) begin
            w_state_nxt = SUM_LO;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        SUM_LO: begin
          w_out_nxt   = r_sum[15:0];
          w_state_nxt = SUM_HI;
        end
        SUM_HI: begin
          w_out_nxt   = r_sum[31:16];
          w_state_nxt = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Scoreboard bench for reg_dump_ctrl: each press queues the expected LED,
// busy and read-address triple; a monitor applies and checks them per cycle.
module tb_reg_dump_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        nxt;
  logic [15:0] sw;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        busy;
  logic [15:0] led;
  logic [31:0] regs [32];

  typedef struct packed {
    logic [15:0] o;
    logic        b;
    logic [4:0]  a;
  } step_t;

  typedef struct {
    int unsigned due;
    step_t       s;
  } exp_t;

  step_t       pend[$];
  exp_t        sb[$];
  step_t       cur = '0;
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rd_data = regs[rd_addr];

  reg_dump_ctrl #(.NREG_LOG2(5), .DW(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (sw),
    .nxt     (nxt),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy),
    .out     (led)
  );

  // Reference: the full list of displays a sequence produces, from the switch word
  task automatic build_seq(input logic [15:0] w);
    logic [4:0]  s;
    logic [31:0] d;
    logic [31:0] sum;
    s = w[4:0];
    pend.push_back(step_t'({16'h0001, 1'b1, s}));
    if (!w[15]) begin
      d = regs[s];
      pend.push_back(step_t'({d[15:0], 1'b1, s}));
      pend.push_back(step_t'({d[31:16], 1'b1, s}));
      pend.push_back(step_t'({16'(s), 1'b0, s}));
    end else begin
      sum = 32'h0;
      for (int r = int'(s); r < 32; r++) begin
        d = regs[r];
        sum = sum ^ d;
        pend.push_back(step_t'({d[15:0], 1'b1, 5'(r)}));
        pend.push_back(step_t'({d[31:16], 1'b1, 5'(r)}));
        pend.push_back(step_t'({16'(r), 1'b1, (r == 31) ? 5'd31 : 5'(r + 1)}));
      end
      pend.push_back(step_t'({sum[15:0], 1'b1, 5'd31}));
      pend.push_back(step_t'({sum[31:16], 1'b0, 5'd31}));
    end
  endtask

  task automatic press(input int hold, input int gap);
    exp_t e;
    @(negedge clk);
    if (pend.size() == 0) build_seq(sw);
    e.s   = pend.pop_front();
    e.due = cyc + 3;
    sb.push_back(e);
    nxt = 1'b1;
    repeat (hold) @(negedge clk);
    nxt = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic rpress();
    press($urandom_range(6, 1), $urandom_range(5, 2));
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    @(negedge clk);
    reset = 1'b1;
    pend.delete();
    e.s   = '0;
    e.due = cyc + 1;
    sb.push_back(e);
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  // Press until the current sequence completes, optionally scrambling switches mid-way
  task automatic run_seq(input logic [15:0] w, input bit scramble);
    sw = w;
    rpress();
    while (pend.size() > 0) begin
      if (scramble) sw = 16'($urandom);
      rpress();
    end
  endtask

  // Monitor: apply due expectations, then compare every cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.due < cyc) begin
          checks++;
          failures++;
          $display("FAIL expect_timing due=%0d now=%0d", e.due, cyc);
        end
        cur = e.s;
      end
      checks++;
      if ({led, busy, rd_addr} !== cur) begin
        failures++;
        $display("FAIL cyc%0d out/busy/rd_addr got %h/%b/%0d want %h/%b/%0d",
                 cyc, led, busy, rd_addr, cur.o, cur.b, cur.a);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int waited;
    reset = 1'b1;
    nxt   = 1'b1;
    sw    = 16'h0000;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;

    // Reset with button held; holding it afterwards must not step
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    nxt = 1'b0;
    repeat (3) @(negedge clk);

    // Single read of R5
    regs[5] = 32'hDEADBEEF;
    sw = 16'h0005;
    repeat (4) press(2, 3);

    // Scan tail R30..R31 with checksum
    regs[30] = 32'h00010001;
    regs[31] = 32'h00020003;
    run_seq(16'h801E, 1'b0);

    // Long hold is one step only
    sw = 16'h0002;
    press(50, 3);
    repeat (3) press(1, 2);

    // Reset in the middle of a scan, then a fresh scan
    sw = 16'h8000;
    repeat (10) rpress();
    do_reset(2);
    repeat (3) @(negedge clk);
    run_seq(16'h801B, 1'b0);

    // Ignored switch bits; switches changed at SHOW_HI
    sw = 16'h7FE3;
    press(2, 3);
    press(2, 3);
    sw = 16'h0010;
    press(2, 3);
    press(2, 3);

    // Randomized sequences with scrambled switches mid-sequence
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      run_seq({1'($urandom), 10'($urandom), 5'($urandom_range(31, 18))}, 1'b1);
    end

    // Random reset part-way through a sequence
    sw = 16'h8010;
    repeat ($urandom_range(12, 2)) rpress();
    do_reset(1);
    repeat (3) @(negedge clk);
    run_seq(16'h0007, 1'b1);

    waited = 0;
    while (sb.size() > 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d want 0", sb.size());
    end
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
